// File: rtl/disp_pkg.sv
// Shared types and constants for the display datapath (binary-to-BCD front end).
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } b2b_state_t;

    // Nibbles at or above this value get the +3 correction before each shift
    localparam logic [3:0] NIB_ADJ_THR = 4'd5;
    localparam logic [3:0] NIB_ADJ_ADD = 4'd3;

    // Largest value representable in the given number of BCD digits (10**digits - 1)
    function automatic int unsigned max_bcd_val(input int unsigned digits);
        int unsigned v;
        v = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_adj.sv
// Single BCD digit correction for double-dabble: +3 when the nibble is 5 or more.
module bcd_digit_adj
    import disp_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout_c
);

    // Pre-shift correction; input is at most 9 so the 4-bit sum never exceeds 12
    always_comb begin
        dout_c = (din >= NIB_ADJ_THR) ? (din + NIB_ADJ_ADD) : din;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary to packed BCD converter feeding the 7-seg driver.
// Optional build macro BCD_SAT_EN: saturate bcd to all-nines on overflow
// instead of reporting the truncated (mod 10**DIGITS) value.
module bin_to_bcd_seq
    import disp_pkg::*;
#(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int unsigned BCD_W       = 4 * DIGITS;
    localparam int unsigned CNT_W       = $clog2(BIN_W + 1);
    localparam int unsigned MAX_BCD_VAL = max_bcd_val(DIGITS);

    localparam logic [BCD_W-1:0] SAT_VAL  = {DIGITS{4'h9}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    b2b_state_t         state_q, state_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]   scr_q, scr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_next_q, ovf_next_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]   scr_adj;
    logic [BCD_W-1:0]   scr_shift;
    logic [BCD_W-1:0]   bcd_final;

    // Per-digit +3 correction, all digits in parallel
    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .din    (scr_q[4*k+3 -: 4]),
            .dout_c (scr_adj[4*k+3 -: 4])
        );
    end

    // Adjusted scratch shifted left; the bit leaving the top digit is dropped
    always_comb begin
        scr_shift = BCD_W'({scr_adj, shreg_q[BIN_W-1]});
    end

    // Value published on completion: truncated or saturated on overflow
    always_comb begin
`ifdef BCD_SAT_EN
        bcd_final = ovf_next_q ? SAT_VAL : scr_shift;
`else
        bcd_final = scr_shift;
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        scr_d      = scr_q;
        cnt_d      = cnt_q;
        ovf_next_d = ovf_next_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d    = SHIFT;
                    shreg_d    = bin;
                    scr_d      = '0;
                    cnt_d      = '0;
                    ovf_next_d = (32'(bin) > MAX_BCD_VAL);
                    busy_d     = 1'b1;
                end
            end
            SHIFT: begin
                scr_d   = scr_shift;
                shreg_d = BIN_W'({shreg_q, 1'b0});
                cnt_d   = cnt_q + CNT_W'(1);
                // Last iteration: publish so bcd/ovf/done appear together in DONE
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    bcd_d   = bcd_final;
                    ovf_d   = ovf_next_q;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_next_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scr_q      <= scr_d;
            cnt_q      <= cnt_d;
            ovf_next_q <= ovf_next_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule
